risc16_boot_loader: RTL and testbench

Boot sequencer for the risc16p core: holds the core in reset, receives a program image as a byte stream over a valid/ready handshake, writes it as 16-bit words into instruction memory, verifies an XOR checksum, then releases the core. It sits between the host/UART receive path and the instruction-memory write port, and drives the core's `rst` input. A `reload` pulse re-enters loading at any time after a load has finished or failed.

---
 rtl/risc16_pkg.sv | 20 ++
 rtl/risc16_boot_loader.sv | 132 +++++++++++++
 tb/tb_risc16_boot_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared types and constants for the risc16p core and its boot
// loader.
//   boot_state_t   : boot loader FSM states
//   BOOT_ADDR_STEP : byte distance between consecutive instruction words
//                    (also the core's PC increment)
package risc16_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DAT_HI = 3'd2,
    DAT_LO = 3'd3,
    CSUM   = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } boot_state_t;

  localparam logic [15:0] BOOT_ADDR_STEP = 16'd2;

endpackage

// File: rtl/risc16_boot_loader.sv
// risc16_boot_loader: holds the risc16p core in reset while a program image
// arrives as a byte stream, writes it into instruction memory as 16-bit words,
// checks an XOR checksum and then releases the core.
//
// Stream: LEN_HI LEN_LO (word count N, big-endian), N x (HI LO), CSUM.
// CSUM must equal the XOR of every byte before it, length bytes included.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_data/valid/ready byte stream in
//   mem_addr/wdata/we   instruction-memory write port (registered, 1-cycle we)
//   core_rst            registered reset to the core, low only in RUN
//   reload              restart loading (honoured only in RUN or ERR)
//   busy, done, err     status: loading / running / load failed
//   boot_state          current FSM state, for observation
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_ready depends only on the state; it is high throughout a load and low in
// RUN and ERR, so there is never back-pressure inside a load.
module risc16_boot_loader
  import risc16_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        core_rst,
  input  logic        reload,
  output logic        busy,
  output logic        done,
  output logic        err,
  output boot_state_t boot_state
);

  boot_state_t state;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [7:0]  word_hi;
  logic [7:0]  csum;

  logic        accept;
  logic [15:0] new_len;
  logic [15:0] cnt_next;

  assign busy       = (state == LEN_HI) || (state == LEN_LO) || (state == DAT_HI) ||
                      (state == DAT_LO) || (state == CSUM);
  assign rx_ready   = busy;
  assign done       = (state == RUN);
  assign err        = (state == ERR);
  assign boot_state = state;

  assign accept   = rx_valid && rx_ready;
  assign new_len  = {len[15:8], rx_data};
  assign cnt_next = cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LEN_HI;
      len       <= '0;
      cnt       <= '0;
      word_hi   <= '0;
      csum      <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      core_rst  <= 1'b1;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      mem_we <= 1'b0;
      case (state)
        LEN_HI: if (accept) begin
          len[15:8] <= rx_data;
          csum      <= csum ^ rx_data;
          state     <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          len  <= new_len;
          csum <= csum ^ rx_data;
          if (new_len == 16'd0) begin
            state <= CSUM;
          end else if (new_len > MAX_WORDS) begin
            state <= ERR;
          end else begin
            cnt   <= '0;
            state <= DAT_HI;
          end
        end
        DAT_HI: if (accept) begin
          word_hi <= rx_data;
          csum    <= csum ^ rx_data;
          state   <= DAT_LO;
        end
        DAT_LO: if (accept) begin
          csum      <= csum ^ rx_data;
          mem_we    <= 1'b1;
          // 16-bit sum: addresses wrap past 16'hFFFE back to 16'h0000.
          mem_addr  <= BASE_ADDR + 16'(cnt * BOOT_ADDR_STEP);
          mem_wdata <= {word_hi, rx_data};
          cnt       <= cnt_next;
          state     <= (cnt_next == len) ? CSUM : DAT_HI;
        end
        CSUM: if (accept) begin
          if (rx_data == csum) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end else begin
            state <= ERR;
          end
        end
        RUN, ERR: if (reload) begin
          state    <= LEN_HI;
          core_rst <= 1'b1;
          csum     <= '0;
          len      <= '0;
          cnt      <= '0;
        end
        default: begin
          state    <= ERR;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc16_boot_loader.sv
// Directed bench for risc16_boot_loader. Instance a uses default parameters;
// instance b uses BASE_ADDR=16'hFFFE, MAX_WORDS=4 for the oversize-length and
// address-wrap cases. Inputs change on the falling edge, outputs are sampled on
// the falling edge.
module tb_risc16_boot_loader;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        reload_a = 1'b0, reload_b = 1'b0;

  logic        ready_a, we_a, core_rst_a, busy_a, done_a, err_a;
  logic [15:0] addr_a, wdata_a;
  boot_state_t state_a;
  logic        ready_b, we_b, core_rst_b, busy_b, done_b, err_b;
  logic [15:0] addr_b, wdata_b;
  boot_state_t state_b;

  int checks = 0;
  int errors = 0;
  int we_cnt_a = 0, we_cnt_b = 0;
  logic prev_we_a = 1'b0, prev_we_b = 1'b0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  always #5 clk = ~clk;

  risc16_boot_loader dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(valid_a), .rx_ready(ready_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a), .core_rst(core_rst_a),
    .reload(reload_a), .busy(busy_a), .done(done_a), .err(err_a), .boot_state(state_a)
  );

  risc16_boot_loader #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(16'd4)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(valid_b), .rx_ready(ready_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b), .core_rst(core_rst_b),
    .reload(reload_b), .busy(busy_b), .done(done_b), .err(err_b), .boot_state(state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboards: every strobe must match the next expected {addr, data}
  // and must not directly follow another strobe.
  always @(negedge clk) begin
    if (we_a) begin
      we_cnt_a++;
      if (exp_q_a.size() == 0) chk("wr_a_unexpected", {addr_a, wdata_a}, 32'hxxxxxxxx);
      else chk("wr_a", {addr_a, wdata_a}, exp_q_a.pop_front());
      chk("we_a_one_cycle", {31'd0, prev_we_a}, 32'd0);
    end
    prev_we_a = we_a;
  end

  always @(negedge clk) begin
    if (we_b) begin
      we_cnt_b++;
      if (exp_q_b.size() == 0) chk("wr_b_unexpected", {addr_b, wdata_b}, 32'hxxxxxxxx);
      else chk("wr_b", {addr_b, wdata_b}, exp_q_b.pop_front());
      chk("we_b_one_cycle", {31'd0, prev_we_b}, 32'd0);
    end
    prev_we_b = we_b;
  end

  // Present one byte to instance sel until it is accepted (bounded).
  task automatic send_byte(input int sel, input logic [7:0] b, input bit thr);
    bit sent = 0;
    int n = 0;
    logic v, rdy;
    while (!sent && n < 200) begin
      @(negedge clk);
      v = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data = b;
      if (sel == 0) valid_a = v; else valid_b = v;
      rdy = (sel == 0) ? ready_a : ready_b;
      @(posedge clk);
      if (v && rdy) sent = 1;
      n++;
    end
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (!sent) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bytes(input int sel, input logic [7:0] s[$], input bit thr);
    foreach (s[i]) send_byte(sel, s[i], thr);
  endtask

  task automatic pulse_reload(input int sel);
    @(negedge clk);
    if (sel == 0) reload_a = 1'b1; else reload_b = 1'b1;
    @(posedge clk);
    #1;
    reload_a = 1'b0;
    reload_b = 1'b0;
  endtask

  initial begin
    logic [7:0] s[$];
    int wc;

    // Reset values
    #12;
    chk("rst_state_a", 32'(state_a), 32'(LEN_HI));
    chk("rst_core_rst_a", 32'(core_rst_a), 32'd1);
    chk("rst_we_a", 32'(we_a), 32'd0);
    chk("rst_addr_a", 32'(addr_a), 32'h0000);
    chk("rst_wdata_a", 32'(wdata_a), 32'h0000);
    chk("rst_status_a", {29'd0, busy_a, done_a, err_a}, 32'b100);
    chk("rst_addr_b", 32'(addr_b), 32'hFFFE);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_a_idle", 32'(ready_a), 32'd1);

    // Basic load: 00^02^12^34^AB^CD = 42
    exp_q_a.push_back({16'h0000, 16'h1234});
    exp_q_a.push_back({16'h0002, 16'hABCD});
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_bytes(0, s, 0);
    @(negedge clk);
    chk("basic_pre_csum_core_rst", 32'(core_rst_a), 32'd1);
    chk("basic_pre_csum_state", 32'(state_a), 32'(CSUM));
    send_byte(0, 8'h42, 0);
    @(negedge clk);
    chk("basic_core_rst", 32'(core_rst_a), 32'd0);
    chk("basic_status", {29'd0, busy_a, done_a, err_a}, 32'b010);
    chk("basic_ready", 32'(ready_a), 32'd0);
    chk("basic_writes_left", exp_q_a.size(), 32'd0);

    // Bad checksum, then reload and a good stream 00 01 55 AA (csum FE)
    pulse_reload(0);
    @(negedge clk);
    chk("reload_state", 32'(state_a), 32'(LEN_HI));
    chk("reload_core_rst", 32'(core_rst_a), 32'd1);
    chk("reload_busy", 32'(busy_a), 32'd1);
    exp_q_a.push_back({16'h0000, 16'h1234});
    exp_q_a.push_back({16'h0002, 16'hABCD});
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h4D};
    send_bytes(0, s, 0);
    repeat (2) @(negedge clk);
    chk("bad_status", {29'd0, busy_a, done_a, err_a}, 32'b001);
    chk("bad_core_rst", 32'(core_rst_a), 32'd1);
    chk("bad_ready", 32'(ready_a), 32'd0);
    chk("bad_writes_left", exp_q_a.size(), 32'd0);
    pulse_reload(0);
    exp_q_a.push_back({16'h0000, 16'h55AA});
    s = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFE};
    send_bytes(0, s, 0);
    @(negedge clk);
    chk("reload_good_done", 32'(done_a), 32'd1);
    chk("reload_good_writes_left", exp_q_a.size(), 32'd0);

    // Zero length
    pulse_reload(0);
    wc = we_cnt_a;
    s = '{8'h00, 8'h00, 8'h00};
    send_bytes(0, s, 0);
    repeat (2) @(negedge clk);
    chk("zero_state", 32'(state_a), 32'(RUN));
    chk("zero_core_rst", 32'(core_rst_a), 32'd0);
    chk("zero_no_writes", 32'(we_cnt_a), 32'(wc));

    // Reset mid-load after the high byte of word 1; reload in DAT_LO is ignored
    pulse_reload(0);
    s = '{8'h00, 8'h02, 8'h12};
    send_bytes(0, s, 0);
    pulse_reload(0);
    @(negedge clk);
    chk("reload_ignored", 32'(state_a), 32'(DAT_LO));
    wc = we_cnt_a;
    #1 rst = 1'b1;
    #1;
    chk("midrst_state", 32'(state_a), 32'(LEN_HI));
    chk("midrst_core_rst", 32'(core_rst_a), 32'd1);
    chk("midrst_wdata", 32'(wdata_a), 32'h0000);
    chk("midrst_addr", 32'(addr_a), 32'h0000);
    chk("midrst_status", {29'd0, busy_a, done_a, err_a}, 32'b100);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_writes", 32'(we_cnt_a), 32'(wc));
    // 00^01^BE^EF = 50
    exp_q_a.push_back({16'h0000, 16'hBEEF});
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    send_bytes(0, s, 0);
    @(negedge clk);
    chk("fresh_done", 32'(done_a), 32'd1);
    chk("fresh_writes_left", exp_q_a.size(), 32'd0);

    // Oversize length on instance b (MAX_WORDS=4)
    wc = we_cnt_b;
    s = '{8'h00, 8'h05};
    send_bytes(1, s, 0);
    @(negedge clk);
    chk("over_state", 32'(state_b), 32'(ERR));
    chk("over_err", 32'(err_b), 32'd1);
    chk("over_ready", 32'(ready_b), 32'd0);
    chk("over_no_writes", 32'(we_cnt_b), 32'(wc));

    // Throttled source with wrap, BASE_ADDR=FFFE: 02^11^11^22^22 = 02
    pulse_reload(1);
    exp_q_b.push_back({16'hFFFE, 16'h1111});
    exp_q_b.push_back({16'h0000, 16'h2222});
    s = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h02};
    send_bytes(1, s, 1);
    repeat (2) @(negedge clk);
    chk("wrap_done", 32'(done_b), 32'd1);
    chk("wrap_core_rst", 32'(core_rst_b), 32'd0);
    chk("wrap_writes_left", exp_q_b.size(), 32'd0);
    chk("wrap_write_count", 32'(we_cnt_b), 32'(wc + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
